// File: rtl/ser_uart_pkg.sv
// ser_uart_pkg: shared FSM state types and frame constants for the 8N1 UART.
package ser_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;

endpackage

// File: rtl/ser_uart_if.sv
// ser_uart_if: byte-level handshake between the UART (slave) and its user (master).
interface ser_uart_if;
    import ser_uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_vld;
    logic                 tx_rdy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_vld;
    logic                 rx_rdy;
    logic                 rx_frm_err;
    logic                 rx_ovf;
    logic                 err_clr;

    modport master (
        output tx_data, tx_vld, rx_rdy, err_clr,
        input  tx_rdy, rx_data, rx_vld, rx_frm_err, rx_ovf
    );

    modport slave (
        input  tx_data, tx_vld, rx_rdy, err_clr,
        output tx_rdy, rx_data, rx_vld, rx_frm_err, rx_ovf
    );

endinterface

// File: rtl/ser_uart_baudcnt.sv
// ser_uart_baudcnt: loadable 16-bit down-counter; tick is high while the count is zero.
module ser_uart_baudcnt (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [15:0] val,
    output logic        tick
);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (cnt != '0)
            cnt <= cnt - 16'd1;

    assign tick = cnt == '0;

endmodule

// File: rtl/ser_uart.sv
// ser_uart: full-duplex 8N1 UART with valid/ready byte interfaces and sticky RX error flags.
module ser_uart
    import ser_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rstn,
    input  logic ser_rx,
    output logic ser_tx,
    ser_uart_if.slave bus
);

    localparam logic [15:0] BIT_LD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  LAST    = 3'(DATA_BITS - 1);

    tx_state_t            tx_st;
    logic [DATA_BITS-1:0] tx_sh;
    logic [2:0]           tx_idx;
    logic                 tx_tick;
    logic                 tx_load;

    // Every active state reloads on its tick, so the counter only rests at zero in IDLE.
    assign tx_load = tx_st == TX_IDLE ? bus.tx_vld : tx_tick;

    ser_uart_baudcnt u_tx_cnt (
        .clk  (clk),
        .rstn (rstn),
        .load (tx_load),
        .val  (BIT_LD),
        .tick (tx_tick)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            tx_st      <= TX_IDLE;
            tx_sh      <= '0;
            tx_idx     <= '0;
            ser_tx     <= 1'b1;
            bus.tx_rdy <= 1'b1;
        end else begin
            case (tx_st)
                TX_IDLE:
                    if (bus.tx_vld) begin
                        tx_st      <= TX_START;
                        tx_sh      <= bus.tx_data;
                        ser_tx     <= 1'b0;
                        bus.tx_rdy <= 1'b0;
                    end
                TX_START:
                    if (tx_tick) begin
                        tx_st  <= TX_DATA;
                        ser_tx <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                    end
                TX_DATA:
                    if (tx_tick) begin
                        tx_idx <= tx_idx + 3'd1;
                        if (tx_idx == LAST) begin
                            tx_st  <= TX_STOP;
                            ser_tx <= 1'b1;
                        end else begin
                            ser_tx <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                        end
                    end
                TX_STOP:
                    if (tx_tick) begin
                        tx_st      <= TX_IDLE;
                        bus.tx_rdy <= 1'b1;
                    end
                default: tx_st <= TX_IDLE;
            endcase
        end

    logic [1:0]           sync;
    logic                 rx_s;
    rx_state_t            rx_st;
    logic [DATA_BITS-1:0] rx_sh;
    logic [2:0]           rx_idx;
    logic                 rx_tick;
    logic                 rx_load;
    logic [15:0]          rx_val;
    logic                 deliver;
    logic                 frm_set;
    logic                 consume;
    logic                 ovf_set;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn)
            sync <= 2'b11;
        else
            sync <= {sync[0], ser_rx};

    assign rx_s    = sync[1];
    // Start edge arms a half-bit delay so later samples land mid-bit.
    assign rx_load = (rx_st == RX_IDLE && !rx_s) || (rx_tick && (rx_st == RX_START || rx_st == RX_DATA));
    assign rx_val  = rx_st == RX_IDLE ? HALF_LD : BIT_LD;
    assign deliver = rx_st == RX_STOP && rx_tick && rx_s;
    assign frm_set = rx_st == RX_STOP && rx_tick && !rx_s;
    assign consume = bus.rx_vld && bus.rx_rdy;
    assign ovf_set = deliver && bus.rx_vld && !consume;

    ser_uart_baudcnt u_rx_cnt (
        .clk  (clk),
        .rstn (rstn),
        .load (rx_load),
        .val  (rx_val),
        .tick (rx_tick)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            rx_st          <= RX_IDLE;
            rx_sh          <= '0;
            rx_idx         <= '0;
            bus.rx_data    <= '0;
            bus.rx_vld     <= 1'b0;
            bus.rx_frm_err <= 1'b0;
            bus.rx_ovf     <= 1'b0;
        end else begin
            case (rx_st)
                RX_IDLE:
                    if (!rx_s)
                        rx_st <= RX_START;
                RX_START:
                    if (rx_tick)
                        rx_st <= rx_s ? RX_IDLE : RX_DATA;
                RX_DATA:
                    if (rx_tick) begin
                        rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
                        rx_idx <= rx_idx + 3'd1;
                        if (rx_idx == LAST)
                            rx_st <= RX_STOP;
                    end
                RX_STOP:
                    if (rx_tick)
                        rx_st <= rx_s ? RX_IDLE : RX_WAIT_HI;
                RX_WAIT_HI:
                    if (rx_s)
                        rx_st <= RX_IDLE;
                default: rx_st <= RX_IDLE;
            endcase
            if (deliver && !ovf_set) begin
                bus.rx_data <= rx_sh;
                bus.rx_vld  <= 1'b1;
            end else if (consume) begin
                bus.rx_vld <= 1'b0;
            end
            bus.rx_frm_err <= frm_set || (bus.rx_frm_err && !bus.err_clr);
            bus.rx_ovf     <= ovf_set || (bus.rx_ovf && !bus.err_clr);
        end

endmodule

// File: tb/tb_ser_uart.sv
// tb_ser_uart: directed bench for ser_uart at 8 clocks per bit with an RX byte scoreboard.
module tb_ser_uart;
    import ser_uart_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic rx_line = 1'b1;
    logic loop = 1'b0;
    logic ser_tx;
    logic ser_rx;
    int tests = 0;
    int fails = 0;
    logic [7:0] rx_q[$];

    ser_uart_if bus();

    assign ser_rx = loop ? ser_tx : rx_line;

    ser_uart #(.CLKS_PER_BIT(N)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .ser_rx (ser_rx),
        .ser_tx (ser_tx),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] b);
        for (int i = 0; i < 200 && bus.tx_rdy !== 1'b1; i++) @(negedge clk);
        chk("tx_rdy_wait", bus.tx_rdy, 8'd1);
        bus.tx_data = b;
        bus.tx_vld  = 1'b1;
        @(negedge clk);
        bus.tx_vld  = 1'b0;
    endtask

    task automatic rx_bit(input logic v);
        rx_line = v;
        repeat (N) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
    endtask

    always @(negedge clk) begin
        #2;
        if (rstn && bus.rx_vld && bus.rx_rdy) begin
            if (rx_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL rx_unexpected: got %h expected no byte", bus.rx_data);
            end else begin
                chk("rx_byte", bus.rx_data, rx_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] fr;
        bus.tx_data = 8'h00;
        bus.tx_vld  = 1'b0;
        bus.rx_rdy  = 1'b1;
        bus.err_clr = 1'b0;
        #1 rstn = 1'b0;
        #2;
        chk("rst_ser_tx", ser_tx, 8'd1);
        chk("rst_tx_rdy", bus.tx_rdy, 8'd1);
        chk("rst_rx_vld", bus.rx_vld, 8'd0);
        chk("rst_rx_data", bus.rx_data, 8'h00);
        chk("rst_frm_err", bus.rx_frm_err, 8'd0);
        chk("rst_ovf", bus.rx_ovf, 8'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // TX waveform of 0xA5, with tx_data disturbed after acceptance
        fr = {1'b1, 8'hA5, 1'b0};
        send_tx(8'hA5);
        bus.tx_data = 8'h00;
        for (int j = 0; j < 10 * N; j++) begin
            chk("tx_bit", ser_tx, 8'(fr[j / N]));
            chk("tx_busy", bus.tx_rdy, 8'd0);
            @(negedge clk);
        end
        chk("tx_rdy_80", bus.tx_rdy, 8'd1);

        // loopback, back-to-back
        loop = 1'b1;
        rx_q.push_back(8'h3C);
        rx_q.push_back(8'hFF);
        send_tx(8'h3C);
        send_tx(8'hFF);
        for (int i = 0; i < 400 && rx_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("loop_drain", 8'(rx_q.size()), 8'd0);
        chk("loop_frm_err", bus.rx_frm_err, 8'd0);
        chk("loop_ovf", bus.rx_ovf, 8'd0);

        // short glitch is rejected
        loop = 1'b0;
        repeat (20) @(negedge clk);
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_idle", 8'(dut.rx_st), 8'(RX_IDLE));
        chk("glitch_vld", bus.rx_vld, 8'd0);

        // framing error, break, then a good frame
        rx_frame(8'h55, 1'b0);
        rx_line = 1'b0;
        repeat (40) @(negedge clk);
        chk("frm_err_set", bus.rx_frm_err, 8'd1);
        chk("frm_wait_hi", 8'(dut.rx_st), 8'(RX_WAIT_HI));
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        rx_q.push_back(8'h12);
        rx_frame(8'h12, 1'b1);
        repeat (16) @(negedge clk);
        chk("frm_next_drain", 8'(rx_q.size()), 8'd0);
        chk("frm_next_data", bus.rx_data, 8'h12);
        chk("frm_err_sticky", bus.rx_frm_err, 8'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("frm_err_clr", bus.rx_frm_err, 8'd0);

        // overflow with consumer stalled
        bus.rx_rdy = 1'b0;
        rx_frame(8'h01, 1'b1);
        repeat (8) @(negedge clk);
        chk("ovf_vld1", bus.rx_vld, 8'd1);
        chk("ovf_data1", bus.rx_data, 8'h01);
        chk("ovf_clear1", bus.rx_ovf, 8'd0);
        rx_frame(8'h02, 1'b1);
        repeat (8) @(negedge clk);
        chk("ovf_data_kept", bus.rx_data, 8'h01);
        chk("ovf_set", bus.rx_ovf, 8'd1);
        chk("ovf_vld2", bus.rx_vld, 8'd1);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("ovf_clr", bus.rx_ovf, 8'd0);
        rx_q.push_back(8'h01);
        bus.rx_rdy = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovf_drain", 8'(rx_q.size()), 8'd0);
        chk("ovf_vld_off", bus.rx_vld, 8'd0);

        // reset during TX data bit 3, RX mid-frame via loopback
        loop = 1'b1;
        send_tx(8'h00);
        repeat (34) @(negedge clk);
        chk("tx_bit3", ser_tx, 8'd0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_tx", ser_tx, 8'd1);
        chk("rst_async_rdy", bus.tx_rdy, 8'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_rdy", bus.tx_rdy, 8'd1);
        chk("post_rst_vld", bus.rx_vld, 8'd0);
        chk("post_rst_q", 8'(rx_q.size()), 8'd0);
        chk("post_rst_ser_tx", ser_tx, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ser_uart.md
SER_UART -- requirements
Module: ser_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, clk cycles per bit (25 MHz / 115200); legal range 4..65535.
REQ-002 clk  in  1  sole clock (drp_clk domain, 25 MHz).
REQ-003 rstn  in  1  reset; asynchronous, active-low.
REQ-004 ser_rx  in  1  raw serial input, idle high, asynchronous to clk.
REQ-005 ser_tx  out  1  serial output, idle high, non-inverted (board inversion is external).
REQ-006 tx_data  in  8  byte to transmit.
REQ-007 tx_vld  in  1  tx_data valid.
REQ-008 tx_rdy  out  1  transmitter accepts a byte.
REQ-009 rx_data  out  8  received byte.
REQ-010 rx_vld  out  1  rx_data valid.
REQ-011 rx_rdy  in  1  consumer accepts rx_data.
REQ-012 rx_frm_err  out  1  sticky: stop bit sampled low.
REQ-013 rx_ovf  out  1  sticky: byte dropped because buffer full.
REQ-014 err_clr  in  1  single-cycle clear of both sticky flags.

Function
REQ-015 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-016 TX FSM SHALL have states IDLE, START, DATA, STOP; tx_rdy high only in IDLE.
REQ-017 Byte SHALL be accepted on the cycle where tx_vld and tx_rdy are both high; ser_tx goes low the following cycle.
REQ-018 Each TX bit SHALL be held exactly CLKS_PER_BIT cycles; STOP returns to IDLE after its CLKS_PER_BIT cycles, giving a 10*CLKS_PER_BIT-cycle frame.
REQ-019 tx_data SHALL be registered at acceptance; later changes on tx_data do not affect the frame in flight.
REQ-020 ser_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-021 RX FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HI.
REQ-022 IDLE -> START on synchronized ser_rx = 0; START samples after floor(CLKS_PER_BIT/2) cycles; sample 0 -> DATA, sample 1 -> IDLE (glitch rejected, nothing reported).
REQ-023 DATA SHALL sample every CLKS_PER_BIT cycles, 8 samples shifted LSB first, then STOP.
REQ-024 STOP samples after CLKS_PER_BIT cycles; 1 -> byte delivered, go IDLE; 0 -> set rx_frm_err, discard byte, go WAIT_HI.
REQ-025 WAIT_HI SHALL remain until synchronized ser_rx = 1, then IDLE (no retrigger during break).
REQ-026 RX output SHALL be a one-entry buffer: delivered byte loads rx_data and sets rx_vld the cycle after the stop sample.
REQ-027 rx_vld SHALL stay high and rx_data stable until the cycle rx_vld and rx_rdy are both high.
REQ-028 Delivery while rx_vld = 1 and not consumed that cycle: set rx_ovf, drop new byte, keep old.
REQ-029 Delivery in the same cycle as consumption: load new byte, rx_vld stays 1, no overflow.
REQ-030 err_clr clears both sticky flags; a set event in the same cycle as err_clr SHALL win.
REQ-031 TX and RX SHALL operate fully independently (full duplex).

Reset
REQ-032 While rstn low: ser_tx = 1, tx_rdy = 1, rx_vld = 0, rx_data = 0x00, rx_frm_err = 0, rx_ovf = 0, synchronizer flops = 1, both FSMs IDLE, all counters 0.
REQ-033 Reset mid-frame SHALL abort both directions immediately; no partial byte is delivered after release.

Structure
REQ-034 Package ser_uart_pkg SHALL hold the TX and RX state enumerations and constant DATA_BITS = 8.
REQ-035 One sub-module ser_uart_baudcnt (loadable down-counter, 16 bits, one-cycle tick at zero) SHALL be instantiated once for TX and once for RX.

Verification (CLKS_PER_BIT = 8)
REQ-036 tx 0xA5 -> ser_tx: 0 for 8 cycles, then 1,0,1,0,0,1,0,1 each 8 cycles, 1 for 8; tx_rdy high again 80 cycles after acceptance.
REQ-037 Loopback ser_tx->ser_rx, back-to-back 0x3C, 0xFF with rx_rdy = 1 -> rx_vld pulses with 0x3C then 0xFF, both flags 0.
REQ-038 ser_rx low for 3 cycles then high -> no rx_vld, RX FSM back in IDLE.
REQ-039 Frame 0x55 with stop bit 0, line low 40 cycles, then frame 0x12 -> rx_frm_err = 1, no rx_vld for 0x55, rx_data = 0x12 delivered.
REQ-040 rx_rdy = 0, frames 0x01, 0x02 -> rx_data = 0x01, rx_ovf = 1; err_clr pulse -> rx_ovf = 0.
REQ-041 rstn low during TX data bit 3 -> ser_tx = 1 without a clock edge; after release tx_rdy = 1, rx_vld = 0.
